// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the pipeline hazard controller:
// multiply/divide latencies, operand-use encoding and PC select codes.
package pipe_ctrl_pkg;

    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;
    localparam int MD_CNT_W    = 4;

    localparam logic [1:0] TUSE_NONE = 2'd3;

    localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;

    typedef enum logic [1:0] {
        PC_SEL_SEQ     = 2'b00,
        PC_SEL_HANDLER = 2'b01,
        PC_SEL_EPC     = 2'b10
    } pc_sel_e;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    // A source operand conflicts with a producer when the producer writes the
    // same non-zero register and its result arrives later than it is needed.
    function automatic logic src_hazard(
        input logic [4:0] src,
        input logic [1:0] tuse,
        input logic [4:0] dst,
        input logic [1:0] tnew
    );
        return (src != 5'd0) && (tuse != TUSE_NONE) && (dst == src) && (tnew > tuse);
    endfunction

endpackage

// File: rtl/md_busy_timer.sv
// Multiply/divide occupancy timer: counts the unit's latency after a start.
//   state   | meaning
//   MD_IDLE | unit free, waiting for a start that is not killed
//   MD_BUSY | unit computing; count holds remaining busy cycles
module md_busy_timer
    import pipe_ctrl_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    input  logic kill,
    output logic busy
);

    localparam logic [MD_CNT_W-1:0] MULT_LOAD = MD_CNT_W'(MULT_CYCLES);
    localparam logic [MD_CNT_W-1:0] DIV_LOAD  = MD_CNT_W'(DIV_CYCLES);

    md_state_e             state, state_nxt;
    logic [MD_CNT_W-1:0]   count, count_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= MD_IDLE;
            count <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        case (state)
            MD_IDLE: begin
                if (start && !kill) begin
                    state_nxt = MD_BUSY;
                    count_nxt = is_div ? DIV_LOAD : MULT_LOAD;
                end
            end
            MD_BUSY: begin
                // Starts are ignored here; an exception does not stop the count.
                if (count <= MD_CNT_W'(1)) begin
                    state_nxt = MD_IDLE;
                    count_nxt = '0;
                end else begin
                    count_nxt = count - MD_CNT_W'(1);
                end
            end
            default: begin
                state_nxt = MD_IDLE;
                count_nxt = '0;
            end
        endcase
    end

    assign busy = (state == MD_BUSY);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: data and mult/div stalls, exception flush,
// eret redirect and the saved exception PC.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  d_rs,
    input  logic [4:0]  d_rt,
    input  logic [1:0]  d_tuse_rs,
    input  logic [1:0]  d_tuse_rt,
    input  logic [4:0]  e_dst,
    input  logic [4:0]  m_dst,
    input  logic [1:0]  e_tnew,
    input  logic [1:0]  m_tnew,
    input  logic        d_is_md,
    input  logic        e_md_start,
    input  logic        e_md_div,
    input  logic        exc_req,
    input  logic [31:0] m_pc,
    input  logic        m_bd,
    input  logic        d_eret,
    output logic        stall,
    output logic        pc_en,
    output logic        fd_en,
    output logic        fd_clr,
    output logic        de_clr,
    output logic        em_clr,
    output logic        mw_clr,
    output logic [1:0]  pc_sel,
    output logic [31:0] epc,
    output logic        md_busy
);

    logic data_stall;
    logic md_stall;
    logic any_stall;

    md_busy_timer u_md_timer (
        .clk    (clk),
        .reset  (reset),
        .start  (e_md_start),
        .is_div (e_md_div),
        .kill   (exc_req),
        .busy   (md_busy)
    );

    assign data_stall = src_hazard(d_rs, d_tuse_rs, e_dst, e_tnew)
                      | src_hazard(d_rs, d_tuse_rs, m_dst, m_tnew)
                      | src_hazard(d_rt, d_tuse_rt, e_dst, e_tnew)
                      | src_hazard(d_rt, d_tuse_rt, m_dst, m_tnew);

    assign md_stall  = d_is_md && (md_busy || e_md_start);
    assign any_stall = data_stall || md_stall;

    // Priority: exception flush, then stall, then eret redirect.
    always_comb begin
        stall  = 1'b0;
        pc_en  = 1'b1;
        fd_en  = 1'b1;
        fd_clr = 1'b0;
        de_clr = 1'b0;
        em_clr = 1'b0;
        mw_clr = 1'b0;
        pc_sel = PC_SEL_SEQ;
        if (exc_req) begin
            fd_clr = 1'b1;
            de_clr = 1'b1;
            em_clr = 1'b1;
            mw_clr = 1'b1;
            pc_sel = PC_SEL_HANDLER;
        end else if (any_stall) begin
            stall  = 1'b1;
            pc_en  = 1'b0;
            fd_en  = 1'b0;
            de_clr = 1'b1;
        end else if (d_eret) begin
            fd_clr = 1'b1;
            pc_sel = PC_SEL_EPC;
        end
    end

    // Delay-slot exceptions restart at the branch, one word earlier.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            epc <= '0;
        end else if (exc_req) begin
            epc <= m_bd ? (m_pc - 32'd4) : m_pc;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: combinational vector table plus
// clocked sequences for the mult/div timer, exception, eret and reset.
module tb_pipe_hazard_ctrl;
    import pipe_ctrl_pkg::*;

    logic        clk;
    logic        reset;
    logic [4:0]  d_rs, d_rt, e_dst, m_dst;
    logic [1:0]  d_tuse_rs, d_tuse_rt, e_tnew, m_tnew;
    logic        d_is_md, e_md_start, e_md_div, exc_req, m_bd, d_eret;
    logic [31:0] m_pc;
    logic        stall, pc_en, fd_en, fd_clr, de_clr, em_clr, mw_clr;
    logic [1:0]  pc_sel;
    logic [31:0] epc;
    logic        md_busy;

    int total = 0;
    int bad   = 0;

    pipe_hazard_ctrl dut (
        .clk(clk), .reset(reset),
        .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
        .e_dst(e_dst), .m_dst(m_dst), .e_tnew(e_tnew), .m_tnew(m_tnew),
        .d_is_md(d_is_md), .e_md_start(e_md_start), .e_md_div(e_md_div),
        .exc_req(exc_req), .m_pc(m_pc), .m_bd(m_bd), .d_eret(d_eret),
        .stall(stall), .pc_en(pc_en), .fd_en(fd_en), .fd_clr(fd_clr),
        .de_clr(de_clr), .em_clr(em_clr), .mw_clr(mw_clr), .pc_sel(pc_sel),
        .epc(epc), .md_busy(md_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset) begin
            assert (!(md_busy && e_md_start))
                else $error("e_md_start seen while md unit busy");
        end
    end

    typedef struct {
        string      name;
        logic [4:0] rs, rt;
        logic [1:0] tuse_rs, tuse_rt;
        logic [4:0] edst;
        logic [1:0] etnew;
        logic [4:0] mdst;
        logic [1:0] mtnew;
        logic       is_md, eret, exc;
        logic [8:0] exp;   // {stall,pc_en,fd_en,fd_clr,de_clr,em_clr,mw_clr,pc_sel}
    } vec_t;

    vec_t vecs[12];

    localparam logic [8:0] O_IDLE  = 9'b0_1_1_0_0_0_0_00;
    localparam logic [8:0] O_STALL = 9'b1_0_0_0_1_0_0_00;
    localparam logic [8:0] O_ERET  = 9'b0_1_1_1_0_0_0_10;
    localparam logic [8:0] O_EXC   = 9'b0_1_1_1_1_1_1_01;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [8:0] outs();
        return {stall, pc_en, fd_en, fd_clr, de_clr, em_clr, mw_clr, pc_sel};
    endfunction

    task automatic idle_inputs();
        d_rs = 0; d_rt = 0; d_tuse_rs = TUSE_NONE; d_tuse_rt = TUSE_NONE;
        e_dst = 0; m_dst = 0; e_tnew = 0; m_tnew = 0;
        d_is_md = 0; e_md_start = 0; e_md_div = 0;
        exc_req = 0; m_pc = 0; m_bd = 0; d_eret = 0;
    endtask

    initial begin
        int n;
        //          name          rs rt tus tut edst et mdst mt md er ex exp
        vecs[0]  = '{"idle",       0, 0, 3, 3,  0,  0, 0,  0, 0, 0, 0, O_IDLE};
        vecs[1]  = '{"load_use",   5, 0, 1, 3,  5,  2, 0,  0, 0, 0, 0, O_STALL};
        vecs[2]  = '{"tnew_eq",    5, 0, 1, 3,  5,  1, 0,  0, 0, 0, 0, O_IDLE};
        vecs[3]  = '{"zero_reg",   0, 0, 0, 3,  0,  2, 0,  0, 0, 0, 0, O_IDLE};
        vecs[4]  = '{"rt_m",       0, 7, 3, 0,  0,  0, 7,  1, 0, 0, 0, O_STALL};
        vecs[5]  = '{"rt_unused",  0, 7, 3, 3,  0,  0, 7,  2, 0, 0, 0, O_IDLE};
        vecs[6]  = '{"m_ready",    9, 0, 0, 3,  0,  0, 9,  0, 0, 0, 0, O_IDLE};
        vecs[7]  = '{"rs_other",   4, 0, 0, 3,  5,  2, 6,  2, 0, 0, 0, O_IDLE};
        vecs[8]  = '{"md_free",    0, 0, 3, 3,  0,  0, 0,  0, 1, 0, 0, O_IDLE};
        vecs[9]  = '{"eret",       0, 0, 3, 3,  0,  0, 0,  0, 0, 1, 0, O_ERET};
        vecs[10] = '{"eret_stall", 5, 0, 1, 3,  5,  2, 0,  0, 0, 1, 0, O_STALL};
        vecs[11] = '{"exc_eret",   5, 0, 1, 3,  5,  2, 0,  0, 0, 1, 1, O_EXC};

        idle_inputs();
        reset = 1'b1;
        #2;
        check("rst_outs", 32'(outs()), 32'(O_IDLE));
        check("rst_epc", epc, 32'h0);
        check("rst_busy", 32'(md_busy), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            d_rs = vecs[i].rs; d_rt = vecs[i].rt;
            d_tuse_rs = vecs[i].tuse_rs; d_tuse_rt = vecs[i].tuse_rt;
            e_dst = vecs[i].edst; e_tnew = vecs[i].etnew;
            m_dst = vecs[i].mdst; m_tnew = vecs[i].mtnew;
            d_is_md = vecs[i].is_md; d_eret = vecs[i].eret; exc_req = vecs[i].exc;
            #1;
            check(vecs[i].name, 32'(outs()), 32'(vecs[i].exp));
        end
        @(negedge clk);
        idle_inputs();

        // Mult then div occupancy with an md instruction waiting in D.
        for (int pass = 0; pass < 2; pass++) begin
            @(negedge clk);
            e_md_start = 1; e_md_div = (pass == 1); d_is_md = 1;
            #1;
            check("md_start_stall", 32'(stall), 32'h1);
            check("md_start_busy0", 32'(md_busy), 32'h0);
            @(negedge clk);
            e_md_start = 0; e_md_div = 0;
            #1;
            n = 0;
            for (int k = 0; k < 20 && md_busy; k++) begin
                check("md_busy_stall", 32'(stall), 32'h1);
                n++;
                @(negedge clk);
                #1;
            end
            check(pass ? "div_cycles" : "mult_cycles", n, pass ? 32'd10 : 32'd5);
            check("md_done_stall", 32'(stall), 32'h0);
            d_is_md = 0;
        end

        // Exception, no delay slot.
        @(negedge clk);
        m_pc = 32'h0000_2000; m_bd = 0; exc_req = 1;
        @(negedge clk);
        exc_req = 0;
        #1;
        check("epc_nobd", epc, 32'h0000_2000);

        // Exception in delay slot at address 0 wraps.
        @(negedge clk);
        m_pc = 32'h0; m_bd = 1; exc_req = 1;
        @(negedge clk);
        exc_req = 0;
        #1;
        check("epc_wrap", epc, 32'hFFFF_FFFC);

        // Exception coinciding with md start and a load-use stall.
        @(negedge clk);
        m_pc = 32'h0000_3008; m_bd = 1; exc_req = 1;
        e_md_start = 1; e_md_div = 1; d_is_md = 1;
        e_dst = 5; e_tnew = 2; d_rs = 5; d_tuse_rs = 1;
        #1;
        check("exc_outs", 32'(outs()), 32'(O_EXC));
        @(negedge clk);
        idle_inputs();
        #1;
        check("exc_epc", epc, 32'h0000_3004);
        check("exc_no_md", 32'(md_busy), 32'h0);

        // eret returns to epc without touching it.
        @(negedge clk);
        d_eret = 1;
        #1;
        check("eret_outs", 32'(outs()), 32'(O_ERET));
        @(negedge clk);
        #1;
        check("eret_epc", epc, 32'h0000_3004);
        d_eret = 0;

        // Timer keeps counting through an exception.
        @(negedge clk);
        e_md_start = 1; e_md_div = 0;
        @(negedge clk);
        e_md_start = 0; exc_req = 1; m_pc = 32'h0000_3008; m_bd = 1;
        @(negedge clk);
        exc_req = 0;
        #1;
        n = 1;
        for (int k = 0; k < 20 && md_busy; k++) begin
            n++;
            @(negedge clk);
            #1;
        end
        check("busy_thru_exc", n, 32'd5);

        // Reset during a divide with count at 6.
        @(negedge clk);
        e_md_start = 1; e_md_div = 1;
        @(negedge clk);
        e_md_start = 0; e_md_div = 0;
        repeat (4) @(negedge clk);
        #1;
        check("div_busy_pre", 32'(md_busy), 32'h1);
        #1;
        reset = 1'b1;
        #1;
        check("rst_mid_busy", 32'(md_busy), 32'h0);
        check("rst_mid_epc", epc, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        check("post_rst_busy", 32'(md_busy), 32'h0);
        check("post_rst_outs", 32'(outs()), 32'(O_IDLE));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and reset; reset is asynchronous and active-high: clk  in  1  rising-edge clock; reset  in  1  async active-high reset.
REQ-002 d_rs, d_rt  in  5 each  source registers of the D-stage instruction.
REQ-003 d_tuse_rs, d_tuse_rt  in  2 each  cycles until the D-stage instruction needs the operand; 3 = operand not used.
REQ-004 e_dst, m_dst  in  5 each  destination registers in E and M; 0 = no write.
REQ-005 e_tnew, m_tnew  in  2 each  cycles until the E/M result is available.
REQ-006 d_is_md  in  1  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo.
REQ-007 e_md_start, e_md_div  in  1 each  E-stage instruction starts a mult/div; e_md_div=1 selects div.
REQ-008 exc_req  in  1  exception or interrupt taken at M; m_pc  in  32  M-stage PC; m_bd  in  1  M instruction is in a delay slot.
REQ-009 d_eret  in  1  eret in D.
REQ-010 stall  out  1  freeze PC and F/D, bubble into D/E.
REQ-011 pc_en, fd_en  out  1 each  register enables; fd_clr, de_clr, em_clr, mw_clr  out  1 each  synchronous clears of the pipeline registers.
REQ-012 pc_sel  out  2  00 = sequential/branch, 01 = handler 0x0000_4180, 10 = EPC; epc  out  32  saved exception PC; md_busy  out  1  multiply/divide unit busy.

Function
REQ-013 Data stall SHALL be asserted when d_rs!=0 and either (e_dst==d_rs and e_tnew>d_tuse_rs) or (m_dst==d_rs and m_tnew>d_tuse_rs). The same rule SHALL apply to rt.
REQ-014 MD stall SHALL be asserted when d_is_md and either md_busy or e_md_start.
REQ-015 stall = data stall OR MD stall, gated off when exc_req=1. On stall: pc_en=0, fd_en=0, de_clr=1. Otherwise pc_en=fd_en=1.
REQ-016 The MD timer has states IDLE and BUSY.
  - IDLE: on e_md_start with exc_req=0, load count 5 (mult) or 10 (div) and go to BUSY.
  - BUSY: decrement each cycle; go to IDLE in the cycle after count reaches 1.
  - md_busy = (state==BUSY).
REQ-017 e_md_start SHALL be ignored in BUSY. The D-side stall guarantees it cannot occur there; a bench assertion checks this.
REQ-018 An exc_req on the same edge as e_md_start SHALL suppress the start, because the E instruction is flushed.
REQ-019 A timer already in BUSY SHALL continue counting through an exception.
REQ-020 exc_req=1 (combinational, highest priority) SHALL drive:
  - fd_clr=de_clr=em_clr=mw_clr=1, pc_sel=01, pc_en=1, stall=0;
  - on that edge, epc <= m_bd ? m_pc-4 : m_pc (32-bit wrap).
REQ-021 d_eret with exc_req=0 SHALL drive pc_sel=10 and fd_clr=1, and SHALL NOT modify epc.
REQ-022 If d_eret and stall are both set, stall SHALL win: pc_sel=00 and no clear beyond de_clr.
REQ-023 All outputs except epc and md_busy SHALL be combinational from inputs and state.

Reset
REQ-024 On reset assertion, state SHALL go to IDLE, count to 0 and epc to 0 immediately; outputs SHALL then be stall=0, pc_en=fd_en=1, all clears 0, pc_sel=00 (inputs idle).
REQ-025 Reset during BUSY SHALL abort the timer. md_busy SHALL read 0 from the first cycle after release.

Structure
REQ-026 The shared package pipe_ctrl_pkg SHALL hold:
  - MULT_CYCLES=5, DIV_CYCLES=10;
  - TUSE_NONE=3;
  - PC_SEL_SEQ/HANDLER/EPC encodings;
  - HANDLER_ADDR=0x0000_4180.
REQ-027 The MD timer SHALL be the sub-module md_busy_timer (clk, reset, start, is_div, kill, busy).

Verification
REQ-028 The bench SHALL cover these scenarios:
  - Load-use: e_dst=5, e_tnew=2, d_rs=5, d_tuse_rs=1 -> stall=1, pc_en=0, de_clr=1. With e_tnew=1 -> stall=0.
  - Zero register: d_rs=0, e_dst=0, e_tnew=2, d_tuse_rs=0 -> stall=0.
  - Mult: e_md_start=1, e_md_div=0 -> md_busy high for exactly 5 cycles; d_is_md=1 stalls from the start cycle through the last busy cycle. Div -> 10 cycles.
  - Exception: m_pc=0x3008, m_bd=1, exc_req=1 coinciding with e_md_start and a data stall -> all four clears 1, pc_sel=01, stall=0, epc=0x3004 next cycle, md_busy stays 0.
  - eret: after the above, d_eret=1 -> pc_sel=10, fd_clr=1, epc unchanged at 0x3004.
  - Reset mid-div (count 6) -> md_busy=0 and epc=0 immediately, without a clock edge.
